wb_writer: RTL and testbench

WB_WRITER -- requirements
Module: wb_writer

---
 rtl/wb_writer.sv | 176 +++++++++++++++++
 tb/tb_wb_writer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wb_writer.sv
`default_nettype none
// ============================================================================
//  Module      : wb_writer
//  Description : Writeback buffer that merges ALU and load results into a
//                single register-file write port. A circular FIFO of DEPTH
//                {rd, data} entries drains one entry per cycle and offers
//                decode-stage forwarding from any pending entry.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_writer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,

    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,

    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    output logic        RegWrite,

    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_hit,
    output logic        rs2_hit,
    output logic [31:0] rs1_fwd,
    output logic [31:0] rs2_fwd,

    output logic [3:0]  count
);

    // Pointer width; DEPTH is at least 2 so this is never zero.
    localparam int            PW         = $clog2(DEPTH);
    localparam logic [PW-1:0] C_LAST_IDX = PW'(DEPTH - 1);
    localparam logic [3:0]    C_DEPTH    = 4'(DEPTH);

    // Buffer storage and bookkeeping
    logic [4:0]    rd_q   [DEPTH];
    logic [4:0]    rd_d   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [3:0]    count_q, count_d;

    // Per-cycle control
    logic [3:0]    w_free;
    logic          w_pop;
    logic          w_mem_push;
    logic          w_alu_push;
    logic [PW-1:0] w_slot;
    logic [PW-1:0] w_scan;

    // Circular increment; wraps DEPTH-1 back to 0 for non power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == C_LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Readiness depends only on the registered count so that no valid-to-ready
    // or pop-to-ready combinational path exists (except the documented
    // mem_valid term that lets the ALU take the last slot when loads are idle).
    always_comb begin
        w_free    = C_DEPTH - count_q;
        mem_ready = 1'b0;
        alu_ready = 1'b0;
        if (!rst) begin
            mem_ready = (w_free >= 4'd1);
            alu_ready = (w_free >= 4'd2) || ((w_free == 4'd1) && !mem_valid);
        end
    end

    // Handshake decode: x0 destinations complete the handshake but are dropped.
    always_comb begin
        w_pop      = (count_q != 4'd0);
        w_mem_push = mem_valid && mem_ready && (mem_rd != 5'd0);
        w_alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
    end

    // Next-state: the load is enqueued first (older), the ALU result second.
    always_comb begin
        rd_d   = rd_q;
        data_d = data_q;
        head_d = head_q;
        w_slot = tail_q;
        if (w_mem_push) begin
            rd_d[w_slot]   = mem_rd;
            data_d[w_slot] = mem_data;
            w_slot         = ptr_inc(w_slot);
        end
        if (w_alu_push) begin
            rd_d[w_slot]   = alu_rd;
            data_d[w_slot] = alu_data;
            w_slot         = ptr_inc(w_slot);
        end
        tail_d = w_slot;
        if (w_pop) begin
            head_d = ptr_inc(head_q);
        end
        count_d = count_q - {3'b000, w_pop}
                          + {3'b000, w_mem_push}
                          + {3'b000, w_alu_push};
    end

    // Pointer and occupancy registers; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; contents are only meaningful while occupied, and no
    // push can occur during reset because both readies are held low.
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    // Register-file port driven straight from the head entry; the head is
    // consumed on the same edge the register file captures it.
    always_comb begin
        RegWrite  = w_pop;
        WriteReg  = '0;
        WriteData = '0;
        if (w_pop) begin
            WriteReg  = rd_q[head_q];
            WriteData = data_q[head_q];
        end
    end

    // Forwarding: walk occupied entries oldest to youngest so the last match
    // (the youngest write) wins. Incoming same-cycle transfers are ignored.
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        rs1_fwd = '0;
        rs2_fwd = '0;
        w_scan  = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (4'(k) < count_q) begin
                if ((rs1 != 5'd0) && (rd_q[w_scan] == rs1)) begin
                    rs1_hit = 1'b1;
                    rs1_fwd = data_q[w_scan];
                end
                if ((rs2 != 5'd0) && (rd_q[w_scan] == rs2)) begin
                    rs2_hit = 1'b1;
                    rs2_fwd = data_q[w_scan];
                end
            end
            w_scan = ptr_inc(w_scan);
        end
        if (rst) begin
            rs1_hit = 1'b0;
            rs2_hit = 1'b0;
            rs1_fwd = '0;
            rs2_fwd = '0;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_writer
//  Description : Self-checking bench for wb_writer. Directed scenarios
//                followed by random traffic, all compared against a queue
//                based reference of the writeback buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_writer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic        mem_ready;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        rs1_hit, rs2_hit;
    logic [31:0] rs1_fwd, rs2_fwd;
    logic [3:0]  count;

    int tests = 0;
    int fails = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    wb_writer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_hit   (rs1_hit),
        .rs2_hit   (rs2_hit),
        .rs1_fwd   (rs1_fwd),
        .rs2_fwd   (rs2_fwd),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Youngest pending write to rs, searched over the model queue.
    function automatic void lookup(input logic [4:0] rs, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (rs != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].rd == rs) begin
                    hit = 1'b1;
                    d   = q[i].data;
                end
            end
        end
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model by the edge.
    task automatic step(input logic r,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input bit do_chk);
        int          free;
        logic        e_mr, e_ar, e_rw, h1, h2;
        logic [4:0]  e_wr;
        logic [31:0] e_wd, f1, f2;
        @(negedge clk);
        rst = r;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        rs1 = s1; rs2 = s2;
        #1;
        free = DEPTH - q.size();
        e_mr = !r && (free >= 1);
        e_ar = !r && ((free >= 2) || (free == 1 && !mv));
        e_rw = (q.size() > 0);
        e_wr = e_rw ? q[0].rd : 5'd0;
        e_wd = e_rw ? q[0].data : 32'd0;
        lookup(s1, h1, f1);
        lookup(s2, h2, f2);
        if (r) begin
            h1 = 1'b0; f1 = '0;
            h2 = 1'b0; f2 = '0;
        end
        if (do_chk) begin
            chk("mem_ready", {31'd0, mem_ready}, {31'd0, e_mr});
            chk("alu_ready", {31'd0, alu_ready}, {31'd0, e_ar});
            chk("RegWrite",  {31'd0, RegWrite},  {31'd0, e_rw});
            chk("WriteReg",  {27'd0, WriteReg},  {27'd0, e_wr});
            chk("WriteData", WriteData, e_wd);
            chk("count",     {28'd0, count},     32'(q.size()));
            chk("rs1_hit",   {31'd0, rs1_hit},   {31'd0, h1});
            chk("rs1_fwd",   rs1_fwd, f1);
            chk("rs2_hit",   {31'd0, rs2_hit},   {31'd0, h2});
            chk("rs2_fwd",   rs2_fwd, f2);
        end
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (mv && e_mr && mrd != 5'd0) q.push_back('{rd: mrd, data: md});
            if (av && e_ar && ard != 5'd0) q.push_back('{rd: ard, data: ad});
        end
    endtask

    task automatic idle(input int n, input logic [4:0] s1, input logic [4:0] s2);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, s1, s2, 1'b1);
    endtask

    initial begin
        // Power-on reset: state is unknown before the first edge, so only
        // the second reset cycle is checked.
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 5'd1, 5'd2, 1'b1);
        idle(1, 5'd1, 5'd2);

        // Single ALU write, one cycle of latency, exactly one write.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_00AA, 5'd5, 5'd0, 1'b1);
        idle(3, 5'd5, 5'd0);

        // Simultaneous push: load older than ALU.
        step(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd3, 5'd4, 1'b1);
        idle(4, 5'd3, 5'd4);

        // Fill and backpressure with distinct destinations.
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 5'(8 + 2 * i), 32'h100 + 32'(i), 1'b1, 5'(9 + 2 * i), 32'h200 + 32'(i),
                 5'(8 + 2 * i), 5'(9 + 2 * i), 1'b1);
        idle(6, 5'd10, 5'd13);

        // x0 discard.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 5'd0, 5'd0, 1'b1);
        idle(2, 5'd0, 5'd0);

        // Forwarding picks the youngest of two writes to the same register.
        step(1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 5'd7, 5'd7, 1'b1);
        idle(4, 5'd7, 5'd0);

        // Mid-operation reset with entries pending.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'(20 + i), 32'hA0 + 32'(i), 1'b1, 5'(24 + i), 32'hB0 + 32'(i),
                 5'(20 + i), 5'(24 + i), 1'b1);
        step(1'b1, 1'b1, 5'd28, 32'hC0, 1'b1, 5'd29, 32'hC1, 5'd20, 5'd24, 1'b1);
        idle(4, 5'd21, 5'd25);

        // Random traffic with a small register range to provoke matches,
        // x0 writes and occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0),
                 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'b1);
        end
        idle(6, 5'd1, 5'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
